// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider (clk_div_prog).
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-N counter with restart and freeze, plus the registered clk_out/tick outputs.
// The wrap decision is supplied by the parent, which also uses it to time divisor updates.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic             wrap_i,
  input  logic [CNT_W-1:0] div_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  assign cnt_inc_s = wrap_i ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));

  // Next counter/output values: restart beats counting, idle holds the phase.
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (clr_i) begin
      cnt_d     = {CNT_W{1'b0}};
      clk_out_d = 1'b0;
    end else if (run_i) begin
      cnt_d     = cnt_inc_s;
      clk_out_d = (cnt_inc_s >= (div_i >> 1));
      tick_d    = (cnt_inc_s == {CNT_W{1'b0}});
    end else begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: FSM, divisor load checking and update timing.
// Define CLK_DIV_PROG_GLITCHFREE_EN to defer running divisor changes to the period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_err,
  output logic             upd_pend
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV_C = CNT_W'(MIN_DIV);

  if (DEFAULT_DIV < MIN_DIV) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV must be at least 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_s;
  logic             cfg_err_q;
  logic             load_ok_s, running_s, wrap_s, restart_s;

  assign load_ok_s = div_load && (div_val >= MIN_DIV_C);
  assign running_s = (state_q != ST_IDLE) && en;
  assign wrap_s    = (cnt_s >= (div_q - CNT_W'(1)));

`ifdef CLK_DIV_PROG_GLITCHFREE_EN
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             upd_pend_q;
  logic             boundary_s;

  // A restart counts as a period boundary, so pending values land on it too.
  assign boundary_s = sync || (en && wrap_s);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
        else    state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!en) state_d = ST_IDLE;
`ifdef CLK_DIV_PROG_GLITCHFREE_EN
        else if (load_ok_s && !boundary_s) state_d = ST_PEND;
`endif
        else state_d = ST_RUN;
      end
      ST_PEND: begin
`ifdef CLK_DIV_PROG_GLITCHFREE_EN
        if (!en)             state_d = ST_IDLE;
        else if (boundary_s) state_d = ST_RUN;
        else                 state_d = ST_PEND;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Divisor update and counter restart decisions.
  always_comb begin
    div_d     = div_q;
    restart_s = 1'b0;
`ifdef CLK_DIV_PROG_GLITCHFREE_EN
    pend_d = pend_q;
    if (running_s && !boundary_s) begin
      if (load_ok_s) pend_d = div_val;
      else           pend_d = pend_q;
    end else if (load_ok_s) begin
      div_d = div_val;
    end else if (state_q == ST_PEND) begin
      div_d = pend_q;
    end else begin
      div_d = div_q;
    end
`else
    if (load_ok_s) begin
      div_d     = div_val;
      restart_s = running_s;
    end else begin
      div_d = div_q;
    end
`endif
  end

  // Divisor, error and pending registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= DEF_DIV_C;
      cfg_err_q  <= 1'b0;
`ifdef CLK_DIV_PROG_GLITCHFREE_EN
      pend_q     <= DEF_DIV_C;
      upd_pend_q <= 1'b0;
`endif
    end else begin
      div_q      <= div_d;
      cfg_err_q  <= div_load && !load_ok_s;
`ifdef CLK_DIV_PROG_GLITCHFREE_EN
      pend_q     <= pend_d;
      upd_pend_q <= (state_d == ST_PEND);
`endif
    end
  end

  clk_div_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .run_i    (en),
    .clr_i    (sync || restart_s),
    .wrap_i   (wrap_s),
    .div_i    (div_q),
    .cnt_o    (cnt_s),
    .clk_out_o(clk_out),
    .tick_o   (tick)
  );

  assign cfg_err = cfg_err_q;
`ifdef CLK_DIV_PROG_GLITCHFREE_EN
  assign upd_pend = upd_pend_q;
`else
  assign upd_pend = 1'b0;
`endif

endmodule
